// File: rtl/sync_mton_lane_fifo_if.sv
// Bundle of the lane FIFO's write, read and status signals. The FIFO takes the
// slave modport and the producer/consumer side takes the master modport.
interface sync_mton_lane_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int M_WRITERS = 4,
  parameter int N_READERS = 2
);
  logic                          i_flush;
  logic [M_WRITERS-1:0]          i_wr_en;
  logic [M_WRITERS*WIDTH-1:0]    i_wr_data;
  logic                          o_wr_full;
  logic                          o_wr_pfull;
  logic                          o_ovf;
  logic [N_READERS-1:0]          i_rd_en;
  logic [N_READERS*WIDTH-1:0]    o_rd_data;
  logic [N_READERS-1:0]          o_rd_valid;
  logic                          o_rd_empty;
  logic                          o_rd_pempty;
  logic [DEPTH:0]                o_level;

  modport master (
    output i_flush, i_wr_en, i_wr_data, i_rd_en,
    input  o_wr_full, o_wr_pfull, o_ovf, o_rd_data, o_rd_valid,
           o_rd_empty, o_rd_pempty, o_level
  );

  modport slave (
    input  i_flush, i_wr_en, i_wr_data, i_rd_en,
    output o_wr_full, o_wr_pfull, o_ovf, o_rd_data, o_rd_valid,
           o_rd_empty, o_rd_pempty, o_level
  );
endinterface

// File: rtl/sync_mton_lane_fifo.sv
// Single-clock lane FIFO: up to M_WRITERS lanes packed in per cycle, up to
// N_READERS lanes handed out per cycle with registered per-reader valid/data.
module sync_mton_lane_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int M_WRITERS = 4,
  parameter int N_READERS = 2,
  parameter int PFULL_TH  = 12,
  parameter int PEMPTY_TH = 2
) (
  input logic                    i_clk,
  input logic                    i_rstn,
  sync_mton_lane_fifo_if.slave   bus
);
  localparam int CAP      = 2**DEPTH;
  localparam int LW       = DEPTH + 1;
  localparam int WN_W     = $clog2(M_WRITERS) + 1;
  localparam int RN_W     = $clog2(N_READERS) + 1;
  localparam int FULL_LVL = CAP - M_WRITERS;

  // Handshake: there is no backpressure per lane. A write cycle is all-or-nothing
  // (accepted only while o_wr_full is low, otherwise dropped and o_ovf set), and
  // each enabled reader is answered one cycle later by o_rd_valid/o_rd_data.
  logic [WIDTH-1:0]           r_mem [CAP];
  logic [DEPTH-1:0]           r_wptr;
  logic [DEPTH-1:0]           r_rptr;
  logic [LW-1:0]              r_level;
  logic                       r_ovf;
  logic [N_READERS*WIDTH-1:0] r_rd_data;
  logic [N_READERS-1:0]       r_rd_valid;

  logic                       w_full;
  logic [LW-1:0]              w_wcnt;
  logic [LW-1:0]              w_rcnt;
  logic [WN_W-1:0]            w_wn;
  logic [RN_W-1:0]            w_rn;
  logic [LW-1:0]              w_wn_acc;
  logic [LW-1:0]              w_rn_l;
  logic [DEPTH-1:0]           w_wofs [M_WRITERS];
  logic [DEPTH-1:0]           w_raddr [N_READERS];
  logic [N_READERS-1:0]       w_grant;
  logic [N_READERS*WIDTH-1:0] w_rd_next;

  assign w_full = (r_level > LW'(FULL_LVL));

  // Each lane's offset is the number of enabled lanes below it, giving dense packing.
  always_comb begin
    w_wcnt  = '0;
    w_rcnt  = '0;
    w_grant = '0;
    w_rd_next = '0;
    for (int k = 0; k < M_WRITERS; k++) begin
      w_wofs[k] = w_wcnt[DEPTH-1:0];
      if (bus.i_wr_en[k]) w_wcnt = w_wcnt + LW'(1);
    end
    for (int r = 0; r < N_READERS; r++) begin
      w_raddr[r] = r_rptr + w_rcnt[DEPTH-1:0];
      if (bus.i_rd_en[r] && (w_rcnt < r_level)) begin
        w_grant[r] = 1'b1;
        w_rd_next[r*WIDTH +: WIDTH] = r_mem[w_raddr[r]];
        w_rcnt = w_rcnt + LW'(1);
      end
    end
    w_wn     = WN_W'(w_wcnt);
    w_rn     = RN_W'(w_rcnt);
    w_wn_acc = w_full ? '0 : LW'(w_wn);
    w_rn_l   = LW'(w_rn);
  end

  always_ff @(posedge i_clk) begin
    if (!bus.i_flush && !w_full) begin
      for (int k = 0; k < M_WRITERS; k++) begin
        if (bus.i_wr_en[k]) r_mem[r_wptr + w_wofs[k]] <= bus.i_wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else if (bus.i_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_wptr     <= r_wptr + w_wn_acc[DEPTH-1:0];
      r_rptr     <= r_rptr + w_rn_l[DEPTH-1:0];
      r_level    <= r_level + w_wn_acc - w_rn_l;
      r_rd_data  <= w_rd_next;
      r_rd_valid <= w_grant;
      if (w_full && (|bus.i_wr_en)) r_ovf <= 1'b1;
    end
  end

  assign bus.o_wr_full   = w_full;
  assign bus.o_wr_pfull  = (r_level >= LW'(PFULL_TH));
  assign bus.o_ovf       = r_ovf;
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_rd_empty  = (r_level == '0);
  assign bus.o_rd_pempty = (r_level <= LW'(PEMPTY_TH));
  assign bus.o_level     = r_level;
endmodule

// File: tb/tb_sync_mton_lane_fifo.sv
// Bench for sync_mton_lane_fifo: queue-based lane model, per-cycle comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sync_mton_lane_fifo;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  logic chk_en;

  sync_mton_lane_fifo_if bus ();

  sync_mton_lane_fifo dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  logic [7:0]  model_q [$];
  logic        exp_ovf;
  logic [15:0] exp_rd_data;
  logic [1:0]  exp_rd_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_ovf      = 1'b0;
    exp_rd_data  = '0;
    exp_rd_valid = '0;
  endtask

  // One clock of the lane model, evaluated with the inputs present at the edge.
  task automatic model_step(input logic fl, input logic [3:0] we, input logic [31:0] wd,
                            input logic [1:0] re);
    int  avail;
    int  g;
    bit  full;
    avail = model_q.size();
    full  = (16 - avail) < 4;
    if (fl) begin
      model_reset();
    end else begin
      g = 0;
      exp_rd_valid = '0;
      exp_rd_data  = '0;
      for (int r = 0; r < 2; r++) begin
        if (re[r] && g < avail) begin
          exp_rd_valid[r] = 1'b1;
          exp_rd_data[r*8 +: 8] = model_q.pop_front();
          g++;
        end
      end
      if (!full) begin
        for (int k = 0; k < 4; k++)
          if (we[k]) model_q.push_back(wd[k*8 +: 8]);
      end else if (|we) begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // driver: apply one cycle of inputs, update the model at the edge, return at edge+1
  task automatic cyc(input logic fl, input logic [3:0] we, input logic [31:0] wd,
                     input logic [1:0] re);
    bus.i_flush   = fl;
    bus.i_wr_en   = we;
    bus.i_wr_data = wd;
    bus.i_rd_en   = re;
    @(posedge clk);
    model_step(fl, we, wd, re);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},  32'(bus.o_level),    32'd0);
    check({tag, "_empty"},  32'(bus.o_rd_empty), 32'd1);
    check({tag, "_pempty"}, 32'(bus.o_rd_pempty), 32'd1);
    check({tag, "_full"},   32'(bus.o_wr_full),  32'd0);
    check({tag, "_pfull"},  32'(bus.o_wr_pfull), 32'd0);
    check({tag, "_ovf"},    32'(bus.o_ovf),      32'd0);
    check({tag, "_valid"},  32'(bus.o_rd_valid), 32'd0);
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("level",  32'(bus.o_level),     32'(model_q.size()));
      check("empty",  32'(bus.o_rd_empty),  32'(model_q.size() == 0));
      check("pempty", 32'(bus.o_rd_pempty), 32'(model_q.size() <= 2));
      check("full",   32'(bus.o_wr_full),   32'((16 - model_q.size()) < 4));
      check("pfull",  32'(bus.o_wr_pfull),  32'(model_q.size() >= 12));
      check("ovf",    32'(bus.o_ovf),       32'(exp_ovf));
      check("rd_valid", 32'(bus.o_rd_valid), 32'(exp_rd_valid));
      check("rd_data",  32'(bus.o_rd_data),  32'(exp_rd_data));
    end
  end

  initial begin
    int lvl;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    rstn     = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_wr_en   = '0;
    bus.i_wr_data = '0;
    bus.i_rd_en   = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_state("rst");
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    chk_en = 1'b1;

    // sparse write packs lanes 1 and 3, then both readers drain them
    cyc(1'b0, 4'b1010, 32'h44332211, 2'b00);
    check("t2_level", 32'(bus.o_level), 32'd2);
    cyc(1'b0, 4'b0000, 32'h0, 2'b11);
    check("t2_data",  32'(bus.o_rd_data),  32'h4422);
    check("t2_valid", 32'(bus.o_rd_valid), 32'h3);
    check("t2_level0", 32'(bus.o_level),   32'd0);

    // only one lane available for two readers
    cyc(1'b0, 4'b0001, 32'h000000AA, 2'b00);
    cyc(1'b0, 4'b0000, 32'h0, 2'b11);
    check("t3_data",  32'(bus.o_rd_data),  32'h00AA);
    check("t3_valid", 32'(bus.o_rd_valid), 32'h1);
    check("t3_empty", 32'(bus.o_rd_empty), 32'd1);

    // fill to capacity, then overflow
    cyc(1'b1, 4'b0000, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, $urandom(), 2'b00);
    check("t4_level12", 32'(bus.o_level),    32'd12);
    check("t4_pfull",   32'(bus.o_wr_pfull), 32'd1);
    check("t4_notfull", 32'(bus.o_wr_full),  32'd0);
    cyc(1'b0, 4'b1111, $urandom(), 2'b00);
    check("t4_level16", 32'(bus.o_level),    32'd16);
    check("t4_full",    32'(bus.o_wr_full),  32'd1);
    cyc(1'b0, 4'b1111, $urandom(), 2'b00);
    check("t4_level_hold", 32'(bus.o_level), 32'd16);
    check("t4_ovf",        32'(bus.o_ovf),   32'd1);

    // move rptr to 14 with 14 lanes stored, then stream across the wrap
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'b0000, 32'h0, 2'b11);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, $urandom(), 2'b00);
    check("t5_start", 32'(bus.o_level), 32'd14);
    // at 14 only two lanes are free, so the first single-lane write is dropped
    cyc(1'b0, 4'b0001, $urandom(), 2'b11);
    check("t5_first", 32'(bus.o_level), 32'd12);
    lvl = 12;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'b0001, $urandom(), 2'b11);
      lvl = lvl - 1;
      check("t5_fall", 32'(bus.o_level), 32'(lvl));
    end
    check("t5_ovf_sticky", 32'(bus.o_ovf), 32'd1);

    // reach 9 lanes, then flush with every request asserted
    cyc(1'b0, 4'b0011, $urandom(), 2'b00);
    check("t6_level9", 32'(bus.o_level), 32'd9);
    cyc(1'b1, 4'b1111, $urandom(), 2'b11);
    check("t6_level", 32'(bus.o_level),    32'd0);
    check("t6_valid", 32'(bus.o_rd_valid), 32'd0);
    check("t6_ovf",   32'(bus.o_ovf),      32'd0);
    check("t6_empty", 32'(bus.o_rd_empty), 32'd1);

    // randomized traffic, alternating read-heavy and write-heavy phases
    for (int i = 0; i < 400; i++) begin
      logic       fl;
      logic [1:0] re;
      fl = ($urandom_range(0, 49) == 0);
      if ((i / 50) % 2 == 0) re = 2'($urandom_range(0, 3));
      else re = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc(fl, 4'($urandom_range(0, 15)), $urandom(), re);
    end

    // asynchronous reset in the middle of a cycle with traffic in flight
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, $urandom(), 2'b01);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 4'($urandom_range(0, 15)), $urandom(), 2'($urandom_range(0, 3)));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
